// File: rtl/motion_beat_detector.sv
// motion_beat_detector: streaming L1-magnitude beat/step detector with
// hysteresis peak tracking, hold-off window, saturating event counter and irq.
// Optional feature macro: MOTION_BASELINE_EN (EMA baseline removal before detection).
module motion_beat_detector #(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned AVG_SHIFT = 3,
    localparam int unsigned MAG_W    = SAMPLE_W + 2
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_x,
    input  logic [SAMPLE_W-1:0] s_y,
    input  logic [SAMPLE_W-1:0] s_z,
    input  logic                cfg_enable,
    input  logic [MAG_W-1:0]    cfg_thresh_hi,
    input  logic [MAG_W-1:0]    cfg_thresh_lo,
    input  logic [15:0]         cfg_holdoff,
    input  logic                clr_count,
    output logic [CNT_W-1:0]    event_count,
    output logic [MAG_W-1:0]    last_peak,
    output logic [MAG_W-1:0]    baseline,
    output logic [1:0]          state,
    output logic                irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PEAK    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // A shift wider than the baseline datapath would discard every update.
    if (AVG_SHIFT > MAG_W) begin : g_bad_shift
        $error("AVG_SHIFT exceeds magnitude width");
    end

    logic                v0, v1, v2, v3;
    logic [SAMPLE_W-1:0] x0, y0, z0;
    logic [SAMPLE_W:0]   ax1, ay1, az1;
    logic [MAG_W-1:0]    mag2;
    logic [MAG_W-1:0]    dev3;

    state_t           state_q, state_next;
    logic [MAG_W-1:0] peak_q, peak_next, peak_max_c, last_peak_next;
    logic [15:0]      hold_q, hold_next;
    logic [CNT_W-1:0] count_next;
    logic             irq_next;

    // Two's-complement magnitude; the most negative input fits in the extra bit.
    function automatic logic [SAMPLE_W:0] abs_val(input logic [SAMPLE_W-1:0] v);
        logic [SAMPLE_W:0] e;
        e = {v[SAMPLE_W-1], v};
        return v[SAMPLE_W-1] ? (~e + (SAMPLE_W+1)'(1)) : e;
    endfunction

    // Always ready once out of reset; stages 0-2: capture, abs, L1 sum.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_ready <= 1'b0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            x0      <= '0;
            y0      <= '0;
            z0      <= '0;
            ax1     <= '0;
            ay1     <= '0;
            az1     <= '0;
            mag2    <= '0;
        end else begin
            s_ready <= 1'b1;
            v0      <= s_valid & s_ready;
            x0      <= s_x;
            y0      <= s_y;
            z0      <= s_z;
            v1      <= v0;
            ax1     <= abs_val(x0);
            ay1     <= abs_val(y0);
            az1     <= abs_val(z0);
            v2      <= v1;
            mag2    <= MAG_W'(ax1) + MAG_W'(ay1) + MAG_W'(az1);
        end
    end

`ifdef MOTION_BASELINE_EN
    logic signed [MAG_W:0] diff_c;
    logic signed [MAG_W:0] step_c;
    logic [MAG_W-1:0]      base_next_c;

    // EMA step toward the current magnitude, floor-rounded by the arithmetic shift.
    always_comb begin
        diff_c      = $signed({1'b0, mag2}) - $signed({1'b0, baseline});
        step_c      = diff_c >>> AVG_SHIFT;
        base_next_c = MAG_W'($signed({1'b0, baseline}) + step_c);
    end

    // Stage 3: deviation against the pre-update baseline, then baseline update.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            v3       <= 1'b0;
            dev3     <= '0;
            baseline <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                dev3     <= (mag2 > baseline) ? (mag2 - baseline) : '0;
                baseline <= base_next_c;
            end
        end
    end
`else
    assign baseline = '0;

    // Stage 3: deviation is the raw magnitude; stage kept for equal latency.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            v3   <= 1'b0;
            dev3 <= '0;
        end else begin
            v3 <= v2;
            if (v2) begin
                dev3 <= mag2;
            end
        end
    end
`endif

    // Detector next-state: enable override, hysteresis peak, hold-off, counting.
    always_comb begin
        state_next     = state_q;
        peak_next      = peak_q;
        hold_next      = hold_q;
        last_peak_next = last_peak;
        count_next     = event_count;
        irq_next       = 1'b0;
        peak_max_c     = (dev3 > peak_q) ? dev3 : peak_q;
        if (!cfg_enable) begin
            state_next = ST_IDLE;
        end else if (v3) begin
            unique case (state_q)
                ST_IDLE: state_next = ST_ARMED;
                ST_ARMED: begin
                    if (dev3 > cfg_thresh_hi) begin
                        state_next = ST_PEAK;
                        peak_next  = dev3;
                    end
                end
                ST_PEAK: begin
                    peak_next = peak_max_c;
                    if (dev3 < cfg_thresh_lo) begin
                        last_peak_next = peak_max_c;
                        irq_next       = 1'b1;
                        if (event_count != '1) begin
                            count_next = event_count + CNT_W'(1);
                        end
                        if (cfg_holdoff == '0) begin
                            state_next = ST_ARMED;
                        end else begin
                            state_next = ST_HOLDOFF;
                            hold_next  = cfg_holdoff;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_next = ST_ARMED;
                    end else begin
                        hold_next = hold_q - 16'(1);
                    end
                end
            endcase
        end
        if (clr_count) begin
            count_next = '0;
        end
    end

    // Detector state and registered status outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            peak_q      <= '0;
            hold_q      <= '0;
            last_peak   <= '0;
            event_count <= '0;
            irq         <= 1'b0;
        end else begin
            state_q     <= state_next;
            peak_q      <= peak_next;
            hold_q      <= hold_next;
            last_peak   <= last_peak_next;
            event_count <= count_next;
            irq         <= irq_next;
        end
    end

    assign state = state_q;

endmodule
